// File: rtl/fpga_link_pkg.sv
// Shared definitions for the inter-FPGA serial link blocks.
// Defaults here are also used by the link transmitter/receiver tops.
package fpga_link_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } link_state_e;

  localparam int LINK_DATA_WIDTH   = 8;
  localparam int LINK_CLKS_PER_BIT = 1;
endpackage

// File: rtl/fpga_bit_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and
// raises tick on the terminal count.
module fpga_bit_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fpga_shift_engine.sv
// Serial shift engine: one start pulse shifts a DATA_WIDTH word out on
// data_out_s while capturing data_in_s into the same register.
module fpga_shift_engine
  import fpga_link_pkg::*;
#(
  parameter int DATA_WIDTH   = LINK_DATA_WIDTH,
  parameter int CLKS_PER_BIT = LINK_CLKS_PER_BIT,
  parameter int LSB_FIRST    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_p,
  input  logic                  load,
  input  logic                  start,
  input  logic                  data_in_s,
  output logic                  data_out_s,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  link_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tick;

  // Divider is held clear outside SHIFT, so every transfer starts a fresh period.
  fpga_bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clock (clock),
    .reset (reset),
    .en    (state_q == SHIFT),
    .clr   (state_q != SHIFT),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (load) sreg_d = data_in_p;
        if (start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (LSB_FIRST != 0) sreg_d = {data_in_s, sreg_q[DATA_WIDTH-1:1]};
          else                sreg_d = {sreg_q[DATA_WIDTH-2:0], data_in_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign data_out   = sreg_q;
  assign data_out_s = (LSB_FIRST != 0) ? sreg_q[0] : sreg_q[DATA_WIDTH-1];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
endmodule

// File: tb/tb_fpga_shift_engine.sv
// Directed bench: instance a is 8-bit/4 clocks per bit/MSB first,
// instance b is 8-bit/1 clock per bit/LSB first.
module tb_fpga_shift_engine;
  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] a_din_p = '0;
  logic       a_load = 1'b0, a_start = 1'b0, a_loop = 1'b0, a_sin_drv = 1'b0;
  logic       a_sin, a_sout, a_busy, a_done;
  logic [7:0] a_dout;

  logic [7:0] b_din_p = '0;
  logic       b_load = 1'b0, b_start = 1'b0, b_sin = 1'b0;
  logic       b_sout, b_busy, b_done;
  logic [7:0] b_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  assign a_sin = a_loop ? a_sout : a_sin_drv;

  fpga_shift_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) u_a (
    .clock(clock), .reset(reset), .data_in_p(a_din_p), .load(a_load),
    .start(a_start), .data_in_s(a_sin), .data_out_s(a_sout),
    .data_out(a_dout), .busy(a_busy), .done(a_done)
  );

  fpga_shift_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1)) u_b (
    .clock(clock), .reset(reset), .data_in_p(b_din_p), .load(b_load),
    .start(b_start), .data_in_s(b_sin), .data_out_s(b_sout),
    .data_out(b_dout), .busy(b_busy), .done(b_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_din_p = 8'($urandom); a_load = 1'($urandom); a_start = 1'($urandom);
      a_sin_drv = 1'($urandom);
      b_din_p = 8'($urandom); b_load = 1'($urandom); b_start = 1'($urandom);
      b_sin = 1'($urandom);
      step();
    end
    a_load = 0; a_start = 0; b_load = 0; b_start = 0; a_sin_drv = 0; b_sin = 0;
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (a_dout !== 8'h00) $display("FAIL reset_a_dout: got %h want 00", a_dout); else n_pass++;
    n_checks++; if ({a_sout, a_busy, a_done} !== 3'b000) $display("FAIL reset_a_flags: got %b want 000", {a_sout, a_busy, a_done}); else n_pass++;
    n_checks++; if (b_dout !== 8'h00) $display("FAIL reset_b_dout: got %h want 00", b_dout); else n_pass++;
    n_checks++; if ({b_sout, b_busy, b_done} !== 3'b000) $display("FAIL reset_b_flags: got %b want 000", {b_sout, b_busy, b_done}); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  // MSB-first loopback: word comes back unchanged after a full rotation.
  task automatic test_loopback();
    logic [7:0] w;
    int done_cyc;
    w = 8'hA5; done_cyc = 0;
    a_loop = 1; a_din_p = w; a_load = 1; step();
    a_load = 0; a_start = 1; step();
    a_start = 0;
    for (int n = 1; n <= 60; n++) begin
      if (a_done) begin done_cyc = n; break; end
      if (n <= 32) begin
        n_checks++;
        if (a_sout !== w[7 - (n - 1) / 4] || a_busy !== 1'b1)
          $display("FAIL loop_bit: cycle %0d got sout=%b busy=%b want sout=%b busy=1", n, a_sout, a_busy, w[7 - (n - 1) / 4]);
        else n_pass++;
      end
      step();
    end
    n_checks++; if (done_cyc !== 33) $display("FAIL loop_done_cycle: got %0d want 33", done_cyc); else n_pass++;
    n_checks++; if (a_dout !== 8'hA5 || a_busy !== 1'b1) $display("FAIL loop_data: got %h busy=%b want a5 busy=1", a_dout, a_busy); else n_pass++;
    step();
    n_checks++; if ({a_busy, a_done} !== 2'b00) $display("FAIL loop_idle: got %b want 00", {a_busy, a_done}); else n_pass++;
    a_loop = 0;
  endtask

  task automatic test_receive();
    logic [7:0] seq;
    int done_cyc;
    seq = 8'b0101_0011; done_cyc = 0;  // bit i is the i-th serial bit
    b_din_p = 8'h00; b_load = 1; step();
    b_load = 0; b_start = 1; step();
    b_start = 0;
    for (int n = 1; n <= 30; n++) begin
      if (b_done) begin done_cyc = n; break; end
      b_sin = (n <= 8) ? seq[n - 1] : 1'b0;
      step();
    end
    b_sin = 0;
    n_checks++; if (done_cyc !== 9) $display("FAIL rx_done_cycle: got %0d want 9", done_cyc); else n_pass++;
    n_checks++; if (b_dout !== 8'h53) $display("FAIL rx_data: got %h want 53", b_dout); else n_pass++;
    step();
  endtask

  // Same-cycle load+start uses the new word; a mid-transfer load/start is dropped.
  task automatic test_load_start();
    logic [7:0] w;
    int done_cyc, errs;
    w = 8'h3C; done_cyc = 0; errs = 0;
    a_sin_drv = 0; a_din_p = w; a_load = 1; a_start = 1; step();
    a_load = 0; a_start = 0;
    for (int n = 1; n <= 60; n++) begin
      if (a_done) begin done_cyc = n; break; end
      if (n <= 32 && a_sout !== w[7 - (n - 1) / 4]) errs++;
      if (n == 16) begin a_din_p = 8'hFF; a_load = 1; a_start = 1; end
      else begin a_load = 0; a_start = 0; end
      step();
    end
    a_load = 0; a_start = 0;
    n_checks++; if (errs !== 0) $display("FAIL ls_stream: got %0d bad bits want 0", errs); else n_pass++;
    n_checks++; if (done_cyc !== 33) $display("FAIL ls_done_cycle: got %0d want 33", done_cyc); else n_pass++;
    n_checks++; if (a_dout !== 8'h00) $display("FAIL ls_data: got %h want 00", a_dout); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int pulses, done_cyc;
    pulses = 0; done_cyc = 0;
    a_loop = 1; a_din_p = 8'hC3; a_load = 1; step();
    a_load = 0; a_start = 1; step();
    a_start = 0;
    repeat (16) step();  // now in the first cycle of bit 4
    reset = 1; step();
    reset = 0;
    n_checks++; if (a_dout !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", a_dout); else n_pass++;
    n_checks++; if ({a_sout, a_busy, a_done} !== 3'b000) $display("FAIL mid_rst_flags: got %b want 000", {a_sout, a_busy, a_done}); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (a_done) pulses++;
      step();
    end
    n_checks++; if (pulses !== 0) $display("FAIL mid_rst_no_done: got %0d pulses want 0", pulses); else n_pass++;
    a_din_p = 8'h81; a_load = 1; step();
    a_load = 0; a_start = 1; step();
    a_start = 0;
    for (int n = 1; n <= 60; n++) begin
      if (a_done) begin done_cyc = n; break; end
      step();
    end
    n_checks++; if (done_cyc !== 33) $display("FAIL mid_rst_redo_cycle: got %0d want 33", done_cyc); else n_pass++;
    n_checks++; if (a_dout !== 8'h81) $display("FAIL mid_rst_redo_data: got %h want 81", a_dout); else n_pass++;
    a_loop = 0;
    step();
  endtask

  task automatic test_back_to_back();
    int done1, done2;
    done1 = 0; done2 = 0;
    b_sin = 0; b_din_p = 8'h5A; b_load = 1; step();
    b_load = 0; b_start = 1; step();
    b_start = 0;
    for (int n = 1; n <= 30; n++) begin
      if (b_done) begin done1 = n; break; end
      step();
    end
    n_checks++; if (done1 !== 9) $display("FAIL b2b_done1: got %0d want 9", done1); else n_pass++;
    n_checks++; if (b_busy !== 1'b1) $display("FAIL b2b_busy_at_done: got %b want 1", b_busy); else n_pass++;
    step();
    n_checks++; if ({b_busy, b_done} !== 2'b00) $display("FAIL b2b_gap: got %b want 00", {b_busy, b_done}); else n_pass++;
    b_start = 1; step();
    b_start = 0;
    n_checks++; if (b_busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", b_busy); else n_pass++;
    for (int n = 1; n <= 30; n++) begin
      if (b_done) begin done2 = n; break; end
      step();
    end
    n_checks++; if (done2 !== 9) $display("FAIL b2b_done2: got %0d want 9", done2); else n_pass++;
    n_checks++; if (b_dout !== 8'h00) $display("FAIL b2b_data: got %h want 00", b_dout); else n_pass++;
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_loopback();
    test_receive();
    test_load_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fpga_shift_engine.md
# fpga_shift_engine

Parametrised serial shift engine for FPGA-to-FPGA transmission. It supersedes the fixed 8-bit load/shift register. Width, bit order and bit period are configurable. A start/busy/done handshake and an internal bit-period divider let one start pulse move a whole word out serially while simultaneously capturing a word in. It sits between the parallel user logic and the inter-FPGA serial pins; a transmitter and a receiver are the same block with the unused half ignored.

## Interface
- DATA_WIDTH, 8: word length in bits, ≥2.
- CLKS_PER_BIT, 1: clock cycles per serial bit, ≥1.
- LSB_FIRST, 0: 0 = MSB shifted out first, 1 = LSB first.

- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in_p  input  DATA_WIDTH  parallel word to transmit.
- load  input  1  capture data_in_p into the shift register (IDLE only).
- start  input  1  begin a DATA_WIDTH-bit transfer (IDLE only).
- data_in_s  input  1  serial receive bit.
- data_out_s  output  1  serial transmit bit.
- data_out  output  DATA_WIDTH  shift register contents (received word after done).
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at transfer completion.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 writes data_in_p into the register.
  - start=1 goes to SHIFT and clears the bit and divider counters.
  - load and start in the same cycle: the word is captured and the transfer uses the new word.
- SHIFT:
  - Divider counts 0..CLKS_PER_BIT-1. The terminal count is the bit tick.
  - On each tick, the register shifts one position toward the transmit end and data_in_s enters at the opposite end. The bit counter increments.
  - After the DATA_WIDTH-th tick, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- load and start while in SHIFT or DONE are ignored; no queuing.
- Transmit end:
  - LSB_FIRST=0: data_out_s = reg[DATA_WIDTH-1]; shift left; data_in_s enters bit 0.
  - LSB_FIRST=1: data_out_s = reg[0]; shift right; data_in_s enters bit DATA_WIDTH-1.
- data_out_s is combinational from the register, so it is valid in every state, including IDLE.
- busy = (state != IDLE).
- Counter widths: bit counter $clog2(DATA_WIDTH+1); divider max(1,$clog2(CLKS_PER_BIT)). With CLKS_PER_BIT=1, every SHIFT cycle is a tick.
- Reset at any time, including mid-transfer: state IDLE, register 0, counters 0, busy 0, done 0, data_out 0, data_out_s 0. Effective on the next edge; a partial word is discarded.

## Timing
- start sampled at edge t:
  - busy=1 and first bit valid on data_out_s from t+1.
  - Each bit is held CLKS_PER_BIT cycles.
  - data_in_s is sampled on the last cycle of each bit period.
- Last shift occurs at edge t+DATA_WIDTH*CLKS_PER_BIT.
- done=1 during cycle t+DATA_WIDTH*CLKS_PER_BIT+1 with busy still 1. busy=0 the following cycle.
- Earliest next start is accepted the cycle after done.
- Full transfer latency, start to done: DATA_WIDTH*CLKS_PER_BIT+1 cycles.
- data_out holds the received word from the done cycle until the next load, start-shift or reset.

## Structure
- Shared package/include fpga_link_pkg holds:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default DATA_WIDTH and CLKS_PER_BIT, which are shared with the link transmitter/receiver tops.
- One sub-module is natural: fpga_bit_tick, the CLKS_PER_BIT divider with enable/clear and a tick output. It is reused by future link framing blocks.
- Register, bit counter and FSM stay in fpga_shift_engine.

## Test plan
- Reset: hold reset 3 cycles after random activity → data_out=0x00, data_out_s=0, busy=0, done=0.
- Loopback, DATA_WIDTH=8, CLKS_PER_BIT=4, LSB_FIRST=0:
  - Stimulus: data_out_s tied to data_in_s; load 0xA5, start at t.
  - Required: data_out_s sequence is 1,0,1,0,0,1,0,1, each bit 4 cycles; done at t+33; data_out=0xA5.
- Receive, CLKS_PER_BIT=1, LSB_FIRST=1:
  - Stimulus: load 0x00, start; drive data_in_s = 1,1,0,0,1,0,1,0.
  - Required: data_out=0x53 at done; done at t+9.
- Simultaneous load+start with 0x3C → the transmitted stream is 0x3C. load 0xFF and start at SHIFT midpoint → ignored; transfer and timing unchanged.
- Reset asserted at bit 4 of a transfer → next cycle IDLE, data_out=0, no done pulse. A fresh load 0x81/start completes normally.
- Back-to-back: start on the cycle after done → second transfer accepted; busy low exactly one cycle between transfers.
